riscv_proc_dpath_btb_assoc: RTL
===============================

// Module: riscv_proc_dpath_btb_assoc
// PURPOSE
//  Parametrised 2-way set-associative branch target buffer for the fetch stage.
//  Lookup is combinational on current_pc4. Each entry carries a 2-bit saturating
//  direction counter, so btb_taken predicts direction as well as target.
//  One tree-PLRU bit per set picks the victim on allocation.
//  A multi-cycle flush FSM invalidates every set, e.g. on fence.i or ASID change.
// PARAMETERS
//  PC_W      32  PC/target width; bits [1:0] are never stored
//  IDX_BITS   2  set index bits; SETS = 2**IDX_BITS, index = pc4[IDX_BITS+1:2]
//  CTR_INIT   2  counter value written on allocation (2'b10, weakly taken)
// PORTS
//  clk            in   1        clock
//  reset_n        in   1        synchronous reset, active-low
//  current_pc4    in   PC_W     fetch lookup address
//  btb_hit        out  1        a valid way's tag matches current_pc4
//  btb_taken      out  1        btb_hit & counter[1] of the hit way
//  btb_target     out  PC_W     {stored target, 2'b00}; 0 when !btb_hit
//  upd_val        in   1        resolved-branch update strobe (one per cycle)
//  upd_pc4        in   PC_W     PC of the resolved branch
//  upd_target     in   PC_W     resolved target
//  upd_taken      in   1        resolved direction
//  flush          in   1        request full invalidation (pulse)
//  flush_busy     out  1        sweep in progress
// BEHAVIOUR
//  Geometry and reset
//  - TAG_W = PC_W-IDX_BITS-2. Tag is pc4[PC_W-1:IDX_BITS+2]. Target field is target[PC_W-1:2].
//  - Reset (reset_n=0 at posedge): all valid bits=0, all PLRU bits=0, FSM=IDLE.
//    Tag, target and counter arrays are not reset.
//  - Outputs during and after reset: btb_hit=0, btb_taken=0, btb_target=0, flush_busy=0.
//  Lookup (combinational, 0-cycle)
//  - Hit when the way is valid and its tag equals the lookup tag.
//  - If both ways match (illegal, cannot arise from the update rules), way 0 wins.
//  - Lookups never modify PLRU or counters.
//  - While flush_busy=1, btb_hit and btb_taken are forced to 0.
//  Update (upd_val=1, FSM=IDLE, written at posedge)
//  - Hit in way w: target <= upd_target.
//    Counter: taken -> +1 saturating at 3; not taken -> -1 saturating at 0.
//    PLRU[set] <= ~w.
//  - Miss, upd_taken=1: allocate way v, where v = first invalid way (way 0 first),
//    else PLRU[set]. Write valid=1, tag, target, counter=CTR_INIT. PLRU[set] <= ~v.
//  - Miss, upd_taken=0: no state change.
//  - An update is ignored entirely while FSM=SWEEP.
//  - Lookup and update in the same cycle to the same set: the lookup sees
//    pre-update state (no write-through bypass).
//  Flush FSM
//  - IDLE: flush=1 -> SWEEP with sweep_idx=0. flush_busy is registered, so it is
//    high from the next cycle.
//  - SWEEP: each cycle clear both valid bits and PLRU of set sweep_idx, then
//    sweep_idx++.
//    At sweep_idx=SETS-1, clear that set and return to IDLE.
//    flush_busy stays high for exactly SETS cycles.
//  - flush asserted during SWEEP is ignored; it does not restart the sweep.
//  - Reset during SWEEP returns to IDLE and clears all valid bits.
//  - An update coincident with the flush request (FSM still IDLE) is applied,
//    then swept away.
// TESTING
//  1 Reset, then lookup pc4=0x100 -> btb_hit=0, btb_taken=0, btb_target=0,
//    flush_busy=0.
//  2 Update pc4=0x104 tgt=0x200 taken -> next cycle lookup 0x104:
//    hit=1, taken=1, target=0x200.
//    Then two not-taken updates -> hit=1, taken=0. A third not-taken update
//    leaves the counter at 0, not wrapped to 3.
//  3 IDX_BITS=2: allocate 0x010 then 0x110 (both set 0, ways 0 and 1),
//    update-hit 0x010 -> PLRU=1. Allocate 0x210 -> replaces way 1:
//    0x110 misses, 0x010 and 0x210 hit.
//  4 Not-taken update to an absent pc 0x300 -> lookup 0x300 still misses,
//    and PLRU is unchanged.
//  5 Fill all sets, pulse flush -> flush_busy high for exactly 4 cycles.
//    Lookups miss throughout. An update during the sweep is dropped.
//    Afterwards every prior pc misses.
//  6 Assert reset_n=0 on the 2nd sweep cycle -> next cycle: flush_busy=0,
//    all lookups miss, and a new update hits normally.

Source files
------------

// File: rtl/riscv_proc_dpath_btb_assoc.sv
// 2-way set-associative branch target buffer with 2-bit direction counters,
// per-set tree-PLRU replacement and a multi-cycle invalidation sweep.
module riscv_proc_dpath_btb_assoc #(
    parameter int unsigned PC_W     = 32,
    parameter int unsigned IDX_BITS = 2,
    parameter logic [1:0]  CTR_INIT = 2'b10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [PC_W-1:0] current_pc4,
    output logic            btb_hit,
    output logic            btb_taken,
    output logic [PC_W-1:0] btb_target,
    input  logic            upd_val,
    input  logic [PC_W-1:0] upd_pc4,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            flush,
    output logic            flush_busy
);

    localparam int unsigned SETS  = 1 << IDX_BITS;
    localparam int unsigned TAG_W = PC_W - IDX_BITS - 2;
    localparam int unsigned TGT_W = PC_W - 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    // Control state (reset) and entry payload (not reset)
    state_t              r_state;
    logic [IDX_BITS-1:0] r_sweep_idx;
    logic                r_flush_busy;
    logic [1:0]          r_valid [SETS];
    logic [SETS-1:0]     r_plru;
    logic [TAG_W-1:0]    r_tag   [SETS][2];
    logic [TGT_W-1:0]    r_tgt   [SETS][2];
    logic [1:0]          r_ctr   [SETS][2];

    state_t              w_state_nxt;
    logic [IDX_BITS-1:0] w_sweep_idx_nxt;
    logic                w_sweep_clr;
    logic                w_upd_en;

    logic [IDX_BITS-1:0] w_lk_set;
    logic [TAG_W-1:0]    w_lk_tag;
    logic                w_lk_hit0;
    logic                w_lk_hit1;
    logic                w_lk_way;

    logic [IDX_BITS-1:0] w_up_set;
    logic [TAG_W-1:0]    w_up_tag;
    logic                w_up_hit0;
    logic                w_up_hit1;
    logic                w_up_hit;
    logic                w_up_way;
    logic [1:0]          w_ctr_old;
    logic [1:0]          w_ctr_new;
    logic                w_up_wr;

    logic                w_unused;

    assign w_unused = ^{current_pc4[1:0], upd_pc4[1:0], upd_target[1:0]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_sweep_idx  <= '0;
            r_flush_busy <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_sweep_idx  <= w_sweep_idx_nxt;
            r_flush_busy <= (w_state_nxt == ST_SWEEP);
        end
    end

    // FSM next-state
    always_comb begin
        w_state_nxt     = r_state;
        w_sweep_idx_nxt = r_sweep_idx;
        case (r_state)
            ST_IDLE: begin
                if (flush) begin
                    w_state_nxt     = ST_SWEEP;
                    w_sweep_idx_nxt = '0;
                end
            end
            ST_SWEEP: begin
                w_sweep_idx_nxt = r_sweep_idx + IDX_BITS'(1);
                if (r_sweep_idx == IDX_BITS'(SETS - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_sweep_clr = 1'b0;
        w_upd_en    = 1'b0;
        case (r_state)
            ST_IDLE:  w_upd_en    = 1'b1;
            ST_SWEEP: w_sweep_clr = 1'b1;
            default:  w_upd_en    = 1'b0;
        endcase
    end

    // Lookup: way 0 wins a double match; suppressed while sweeping
    assign w_lk_set  = current_pc4[IDX_BITS+1:2];
    assign w_lk_tag  = current_pc4[PC_W-1:IDX_BITS+2];
    assign w_lk_hit0 = r_valid[w_lk_set][0] && (r_tag[w_lk_set][0] == w_lk_tag);
    assign w_lk_hit1 = r_valid[w_lk_set][1] && (r_tag[w_lk_set][1] == w_lk_tag);
    assign w_lk_way  = ~w_lk_hit0;

    assign btb_hit    = (w_lk_hit0 | w_lk_hit1) & ~r_flush_busy;
    assign btb_taken  = btb_hit & r_ctr[w_lk_set][w_lk_way][1];
    assign btb_target = btb_hit ? {r_tgt[w_lk_set][w_lk_way], 2'b00} : '0;
    assign flush_busy = r_flush_busy;

    // Update way select: hit way, else first invalid way, else PLRU victim
    assign w_up_set  = upd_pc4[IDX_BITS+1:2];
    assign w_up_tag  = upd_pc4[PC_W-1:IDX_BITS+2];
    assign w_up_hit0 = r_valid[w_up_set][0] && (r_tag[w_up_set][0] == w_up_tag);
    assign w_up_hit1 = r_valid[w_up_set][1] && (r_tag[w_up_set][1] == w_up_tag);
    assign w_up_hit  = w_up_hit0 | w_up_hit1;

    always_comb begin
        w_up_way = 1'b0;
        if (w_up_hit0) begin
            w_up_way = 1'b0;
        end else if (w_up_hit1) begin
            w_up_way = 1'b1;
        end else if (!r_valid[w_up_set][0]) begin
            w_up_way = 1'b0;
        end else if (!r_valid[w_up_set][1]) begin
            w_up_way = 1'b1;
        end else begin
            w_up_way = r_plru[w_up_set];
        end
    end

    assign w_ctr_old = r_ctr[w_up_set][w_up_way];

    always_comb begin
        w_ctr_new = CTR_INIT;
        if (w_up_hit) begin
            if (upd_taken) begin
                w_ctr_new = (w_ctr_old == 2'd3) ? 2'd3 : w_ctr_old + 2'd1;
            end else begin
                w_ctr_new = (w_ctr_old == 2'd0) ? 2'd0 : w_ctr_old - 2'd1;
            end
        end
    end

    assign w_up_wr = w_upd_en & upd_val & (w_up_hit | upd_taken);

    // Valid and PLRU state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(SETS); i++) begin
                r_valid[i] <= 2'b00;
            end
            r_plru <= '0;
        end else if (w_sweep_clr) begin
            r_valid[r_sweep_idx] <= 2'b00;
            r_plru[r_sweep_idx]  <= 1'b0;
        end else if (w_up_wr) begin
            r_valid[w_up_set][w_up_way] <= 1'b1;
            r_plru[w_up_set]            <= ~w_up_way;
        end
    end

    // Entry payload
    always_ff @(posedge clk) begin
        if (reset_n && w_up_wr) begin
            r_tag[w_up_set][w_up_way] <= w_up_tag;
            r_tgt[w_up_set][w_up_way] <= upd_target[PC_W-1:2];
            r_ctr[w_up_set][w_up_way] <= w_ctr_new;
        end
    end

endmodule
